// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply / divide / multiply-accumulate engine.
// One bit is resolved per clock in CALC (shift-add for multiply,
// restoring shift-subtract for divide); FIX applies signs and accumulation.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MADDU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(7);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [OP_W-1:0]    op_reg, op_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   a_reg, a_next;        // |multiplicand|
  logic [WIDTH-1:0]   b_reg, b_next;        // |multiplier| or |divisor|
  logic [2*WIDTH-1:0] prod_reg, prod_next;  // product, or {remainder, quotient}
  logic [CW-1:0]      count_reg, count_next;
  logic               neg_res_reg, neg_res_next;
  logic               neg_rem_reg, neg_rem_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               div_zero_reg, div_zero_next;

  // Decode of the incoming request and of the latched operation
  logic               in_div, in_signed, in_a_neg, in_b_neg;
  logic [WIDTH-1:0]   in_a_abs, in_b_abs;
  logic               cur_div, cur_signed, cur_acc, cur_sub;

  assign in_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign in_signed = ~op_i[0];
  assign in_a_neg  = in_signed & opdata1_i[WIDTH-1];
  assign in_b_neg  = in_signed & opdata2_i[WIDTH-1];
  assign in_a_abs  = in_a_neg ? -opdata1_i : opdata1_i;
  assign in_b_abs  = in_b_neg ? -opdata2_i : opdata2_i;

  assign cur_div    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  assign cur_signed = ~op_reg[0];
  assign cur_sub    = (op_reg == OP_MSUB) || (op_reg == OP_MSUBU);
  assign cur_acc    = (op_reg == OP_MADD) || (op_reg == OP_MADDU) || cur_sub;

  // Per-iteration datapath and final sign/accumulate correction
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, fix_value;

  // Combinational step logic for CALC and correction logic for FIX
  always_comb begin
    mul_addend = prod_reg[0] ? a_reg : {WIDTH{1'b0}};
    mul_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    div_shift  = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, b_reg});
    // The true difference is below the divisor, so WIDTH bits suffice
    div_diff   = div_shift[WIDTH-1:0] - b_reg;
    quo_fix    = neg_res_reg ? -prod_reg[WIDTH-1:0] : prod_reg[WIDTH-1:0];
    rem_fix    = neg_rem_reg ? -prod_reg[2*WIDTH-1:WIDTH] : prod_reg[2*WIDTH-1:WIDTH];
    prod_fix   = neg_res_reg ? -prod_reg : prod_reg;
    if (cur_div) begin
      fix_value = {rem_fix, quo_fix};
    end else if (cur_sub) begin
      fix_value = acc_reg - prod_fix;
    end else if (cur_acc) begin
      fix_value = acc_reg + prod_fix;
    end else begin
      fix_value = prod_fix;
    end
  end

  // Next-state and register-update logic; annul overrides every state
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    acc_next      = acc_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    prod_next     = prod_reg;
    count_next    = count_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    div_zero_next = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          op_next      = op_i;
          acc_next     = acc_i;
          a_next       = in_a_abs;
          b_next       = in_b_abs;
          neg_res_next = in_a_neg ^ in_b_neg;
          neg_rem_next = in_a_neg;
          count_next   = '0;
          result_next  = '0;
          if (in_div) begin
            prod_next = {{WIDTH{1'b0}}, in_a_abs};
          end else begin
            prod_next = {{WIDTH{1'b0}}, in_b_abs};
          end
          if (in_div && (opdata2_i == '0)) begin
            div_zero_next = 1'b1;
            state_next    = DONE;
          end else begin
            div_zero_next = 1'b0;
            state_next    = CALC;
          end
        end
      end
      CALC: begin
        if (cur_div) begin
          prod_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                       prod_reg[WIDTH-2:0], div_ge};
        end else begin
          prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
        end
        count_next = count_reg + CW'(1);
        if (count_reg == LAST_COUNT) begin
          state_next = FIX;
        end
      end
      FIX: begin
        result_next = fix_value;
        state_next  = DONE;
      end
      DONE: begin
        if (!start_i) begin
          result_next   = '0;
          div_zero_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (annul_i) begin
      state_next    = IDLE;
      result_next   = '0;
      div_zero_next = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      acc_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      prod_reg     <= '0;
      count_reg    <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      acc_reg      <= acc_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      prod_reg     <= prod_next;
      count_reg    <= count_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign result_o   = result_reg;
  assign div_zero_o = div_zero_reg;
  assign ready_o    = (state_reg == DONE);
  assign busy_o     = (state_reg == CALC) || (state_reg == FIX);

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised multi-cycle multiply/divide/accumulate unit that sits beside the execute stage.
- Replaces the single-cycle multiplier, the two-pass MADD/MSUB sequencing and the external divider with one iterative engine.
- Execute drives start_i and holds it (stalling the pipeline) until ready_o; the {HI,LO} result then goes to the HI/LO write path.
- Supports signed/unsigned multiply, divide, multiply-add and multiply-subtract at any WIDTH.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH.
OP_W, 3, width of op_i (fixed encoding below).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start_i  input  1  request; held high by execute until ready_o seen.
annul_i  input  1  cancel current/pending operation (flush/exception).
op_i  input  OP_W  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
opdata1_i  input  WIDTH  multiplicand / dividend.
opdata2_i  input  WIDTH  multiplier / divisor.
acc_i  input  2*WIDTH  current forwarded {HI,LO} for MADD/MSUB.
result_o  output  2*WIDTH  {HI,LO}; for divide HI=remainder, LO=quotient.
ready_o  output  1  result valid.
busy_o  output  1  high in CALC and FIX.
div_zero_o  output  1  divide with zero divisor, valid with ready_o.

Behaviour:
- Reset (rst=0, no clock needed): state IDLE; result_o=0, ready_o=0, busy_o=0, div_zero_o=0; internal counter and registers cleared.
- States: IDLE, CALC, FIX, DONE. annul_i=1 has top priority in every state: next edge goes to IDLE, result_o=0, ready_o=0, div_zero_o=0.
- IDLE: start_i=1 and annul_i=0 accepts the operation on that edge.
  - Latches op_i and acc_i.
  - For signed ops, latches the absolute values of the operands and records the result and remainder signs.
  - Goes to CALC with count=0.
  - Exception: DIV/DIVU with opdata2_i=0 goes straight to DONE with result_o=0 and div_zero_o=1.
- CALC: one bit per cycle, exactly WIDTH cycles; count is $clog2(WIDTH+1) bits; after count reaches WIDTH-1 it moves to FIX.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract; quotient bit = 1 when the partial remainder >= divisor.
- FIX (one cycle): applies sign correction, then accumulation, then registers result_o and goes to DONE.
  - Signed product is negated when the operand signs differ.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - MADD/MADDU: acc + product. MSUB/MSUBU: acc - product. Both modulo 2^(2*WIDTH), no overflow flag.
- Latency: with the accepting edge counted as edge 1, ready_o rises after edge WIDTH+2 (34 for WIDTH=32). Divide-by-zero: ready_o rises after edge 1.
- DONE: ready_o=1; result_o and div_zero_o are held stable.
  - Stays in DONE while start_i=1.
  - Goes to IDLE on the first edge with start_i=0; ready_o, result_o and div_zero_o then return to 0.
  - Exactly one result per handshake.
- Inputs are not re-sampled while not in IDLE; changes to op_i or operands mid-operation have no effect.
- Signed corner cases:
  - DIV of -2^(WIDTH-1) by -1 gives quotient 2^(WIDTH-1) (wraps), remainder 0.
  - MULT of -2^(WIDTH-1) by -2^(WIDTH-1) gives +2^(2*WIDTH-2) exactly.
- Reset asserted mid-operation aborts immediately. The first start after reset release is accepted normally.

Test Plan:
1. WIDTH=32, MULT 0xFFFFFFFE x 0x00000003 -> result_o=0xFFFFFFFF_FFFFFFFA, ready_o after edge 34; MULTU same operands -> 0x00000002_FFFFFFFA.
2. DIV 0xFFFFFFF9 (-7) / 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIVU 0xFFFFFFF9 / 2 -> HI=0x00000001, LO=0x7FFFFFFC; DIV 0x80000000 / 0xFFFFFFFF -> HI=0, LO=0x80000000.
3. DIV 5 / 0 -> ready_o after edge 1, div_zero_o=1, result_o=0; drop start_i -> IDLE next edge, all outputs 0.
4. MSUB acc=0x00000000_00000010, 3 x 7 -> 0xFFFFFFFF_FFFFFFFB; MADDU acc=0xFFFFFFFF_FFFFFFFF, 1 x 1 -> 0x00000000_00000000.
5. Start MULTU, assert annul_i at CALC cycle 10 -> IDLE next edge, ready_o never rises; new DIVU 100 / 7 accepted next cycle -> HI=2, LO=14 after edge 34.
6. Hold start_i 5 extra cycles in DONE -> ready_o and result_o stable throughout; pulse rst low mid-CALC -> all outputs 0 with no clock edge; WIDTH=8 rebuild, MULT 0x80 x 0x80 -> 0x4000, ready after edge 10.
